// File: rtl/rice_reader_if.sv
// rice_reader_if
// RAM read bus between the Rice decoder and its word memory.
//   oRamRead    : one-cycle read strobe, driven by the decoder
//   oRamAddress : 16-bit word address, driven by the decoder
//   iRamData    : 16-bit read data, valid one enabled cycle after the strobe
//                 and held by the RAM until the next read
// Modports: master = decoder side, slave = RAM side.
interface rice_reader_if;
    logic        oRamRead;
    logic [15:0] oRamAddress;
    logic [15:0] iRamData;

    modport master (output oRamRead, output oRamAddress, input iRamData);
    modport slave  (input oRamRead, input oRamAddress, output iRamData);
endinterface

// File: rtl/rice_reader.sv
// rice_reader
// Rice-code decoder for the residual path. Fetches an MSB-first stream of
// 16-bit words, parses a 4-bit Rice parameter header and iSampleCount codes,
// and emits one un-zigzagged signed residual per oValid pulse.
// Ports:
//   iClock, iReset      : clock, synchronous active-high reset
//   iEnable             : clock enable, low freezes everything
//   iStart              : start pulse, honoured only in IDLE
//   iBaseAddress        : word address of the header word
//   iSampleCount        : number of residuals to decode
//   ram                 : RAM read bus (master side)
//   oValid / oResidual  : one-cycle pulse with signed residual
//   oRiceParam          : k from the header
//   oBusy / oDone       : run in progress / end-of-run pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for iStart
// S_HEADER | waiting for 4 bits, then latch k
// S_UNARY  | counting quotient zeros up to the stop bit
// S_BINARY | waiting for k remainder bits, then emit the residual
// S_DONE   | pulse oDone, drop oBusy, discard leftover padding bits
module rice_reader (
    input  logic          iClock,
    input  logic          iReset,
    input  logic          iEnable,
    input  logic          iStart,
    input  logic [15:0]   iBaseAddress,
    input  logic [15:0]   iSampleCount,
    rice_reader_if.master ram,
    output logic          oValid,
    output logic [15:0]   oResidual,
    output logic [3:0]    oRiceParam,
    output logic          oBusy,
    output logic          oDone
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_UNARY,
        S_BINARY,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_buf;
    logic [5:0]  r_vb;
    logic [15:0] r_adr;
    logic [15:0] r_cnt;
    logic [15:0] r_q;
    logic        r_land;
    logic        r_ram_read;
    logic [15:0] r_ram_addr;
    logic        r_valid;
    logic [15:0] r_residual;
    logic [3:0]  r_k;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_buf;
    logic [5:0]  w_vb;
    logic [5:0]  w_lz;
    logic        w_all_zero;
    logic [5:0]  w_k6;
    logic [15:0] w_rem;
    logic [15:0] w_u;
    logic [15:0] w_res;
    logic [5:0]  w_q_add;
    logic [16:0] w_q_sum;
    logic [15:0] w_q_sat;
    logic [5:0]  w_consume;
    state_t      w_state_next;
    logic [5:0]  w_vb_next;
    logic [31:0] w_buf_next;
    logic        w_active;
    logic        w_issue;

    // Read data is merged into the parse view in the cycle it arrives, so a
    // header word read at N+1 is parsed at N+2 and k is visible at N+3.
    always_comb begin
        w_buf = r_buf;
        w_vb  = r_vb;
        if (r_land) begin
            w_buf = r_buf | ({ram.iRamData, 16'h0000} >> r_vb);
            w_vb  = r_vb + 6'd16;
        end
    end

    // Bits below the valid count are always zero, so a plain leading-zero
    // count over the whole word, compared against vb, detects "no stop bit yet".
    always_comb begin
        w_lz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (w_buf[i]) w_lz = 6'(31 - i);
        end
    end

    assign w_all_zero = (w_lz >= w_vb);
    assign w_k6       = {2'b00, r_k};
    assign w_rem      = w_buf[31:16] >> (5'd16 - {1'b0, r_k});
    assign w_u        = (r_q << r_k) | w_rem;
    assign w_res      = (w_u >> 1) ^ {16{w_u[0]}};
    assign w_q_add    = w_all_zero ? w_vb : w_lz;
    assign w_q_sum    = {1'b0, r_q} + {11'b0, w_q_add};
    assign w_q_sat    = w_q_sum[16] ? 16'hFFFF : w_q_sum[15:0];

    always_comb begin
        w_consume    = 6'd0;
        w_state_next = r_state;
        case (r_state)
            S_HEADER: begin
                if (w_vb >= 6'd4) begin
                    w_consume    = 6'd4;
                    w_state_next = (r_cnt == 16'd0) ? S_DONE : S_UNARY;
                end
            end
            S_UNARY: begin
                if (w_all_zero) begin
                    w_consume = w_vb;
                end else begin
                    w_consume    = w_lz + 6'd1;
                    w_state_next = S_BINARY;
                end
            end
            S_BINARY: begin
                if (w_vb >= w_k6) begin
                    w_consume    = w_k6;
                    w_state_next = (r_cnt == 16'd1) ? S_DONE : S_UNARY;
                end
            end
            default: ;
        endcase
    end

    assign w_vb_next  = w_vb - w_consume;
    assign w_buf_next = w_buf << w_consume;
    assign w_active   = (r_state == S_HEADER) || (r_state == S_UNARY) || (r_state == S_BINARY);
    // A read is outstanding while the strobe is up; data landing this cycle
    // is already counted in w_vb_next. No fetch is started for a run that
    // is ending, since those bits would only be discarded.
    assign w_issue    = w_active && (w_state_next != S_DONE) && (w_vb_next <= 6'd16) && !r_ram_read;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state    <= S_IDLE;
            r_buf      <= 32'h0;
            r_vb       <= 6'd0;
            r_adr      <= 16'h0;
            r_cnt      <= 16'h0;
            r_q        <= 16'h0;
            r_land     <= 1'b0;
            r_ram_read <= 1'b0;
            r_ram_addr <= 16'h0;
            r_valid    <= 1'b0;
            r_residual <= 16'h0;
            r_k        <= 4'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (iEnable) begin
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_ram_read <= 1'b0;
            r_land     <= r_ram_read;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_ram_read <= 1'b1;
                        r_ram_addr <= iBaseAddress;
                        r_adr      <= iBaseAddress + 16'd1;
                        r_cnt      <= iSampleCount;
                        r_buf      <= 32'h0;
                        r_vb       <= 6'd0;
                        r_q        <= 16'h0;
                        r_busy     <= 1'b1;
                        r_state    <= S_HEADER;
                    end
                end
                S_HEADER, S_UNARY, S_BINARY: begin
                    r_buf   <= w_buf_next;
                    r_vb    <= w_vb_next;
                    r_state <= w_state_next;
                    if (w_issue) begin
                        r_ram_read <= 1'b1;
                        r_ram_addr <= r_adr;
                        r_adr      <= r_adr + 16'd1;
                    end
                    if (r_state == S_HEADER && w_state_next != S_HEADER) begin
                        r_k <= w_buf[31:28];
                    end
                    if (r_state == S_UNARY) begin
                        r_q <= w_q_sat;
                    end
                    if (r_state == S_BINARY && w_state_next != S_BINARY) begin
                        r_residual <= w_res;
                        r_valid    <= 1'b1;
                        r_q        <= 16'h0;
                        r_cnt      <= r_cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram.oRamRead    = r_ram_read;
    assign ram.oRamAddress = r_ram_addr;
    assign oValid          = r_valid;
    assign oResidual       = r_residual;
    assign oRiceParam      = r_k;
    assign oBusy           = r_busy;
    assign oDone           = r_done;
endmodule
